// File: rtl/softmax_row_max_sub.sv
// softmax_row_max_sub: row maximum search and x[i]-max subtraction stage.
// Buffers one N-element signed row, then emits saturated x[i]-max per element.
//
// Ports:
//   i_clk      clock
//   i_rst      synchronous reset, active-high
//   i_valid    row present on i_row; taken only while o_ready=1
//   i_row      N x DW signed input row, sampled on the acceptance edge
//   o_ready    idle, a row is accepted this cycle
//   o_row      N x DW signed x[i]-max, saturated; held until next result
//   o_max      signed row maximum of the last result
//   o_max_idx  lowest index holding that maximum
//   o_valid    one-cycle pulse when o_row/o_max/o_max_idx update
module softmax_row_max_sub #(
    parameter int N = 32,
    parameter int DW = 16,
    localparam int IW = $clog2(N)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic [N-1:0][DW-1:0]      i_row,
    output logic                      o_ready,
    output logic [N-1:0][DW-1:0]      o_row,
    output logic signed [DW-1:0]      o_max,
    output logic [IW-1:0]             o_max_idx,
    output logic                      o_valid
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SUB,
        DONE
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic signed [DW:0] MIN_EXT =
        {2'b11, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] MIN_VAL =
        {1'b1, {(DW-1){1'b0}}};

    state_t               state;
    logic signed [DW-1:0] row_buf [N];
    logic signed [DW-1:0] max_r;
    logic [IW-1:0]        maxi_r;
    logic [IW-1:0]        idx;

    logic signed [DW-1:0] cur;
    logic signed [DW:0]   diff;
    logic signed [DW-1:0] sat_diff;

    // Single shared element read port feeds both the comparator
    // and the subtractor; the difference is widened by one bit so
    // the full [-(2^DW-1), 0] range is visible before clamping.
    always_comb begin
        cur      = row_buf[idx];
        diff     = {cur[DW-1], cur} - {max_r[DW-1], max_r};
        sat_diff = diff[DW-1:0];
        if (diff < MIN_EXT) begin
            sat_diff = MIN_VAL;
        end
    end

    assign o_ready = (state == IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            o_row     <= '0;
            o_max     <= '0;
            o_max_idx <= '0;
            o_valid   <= 1'b0;
            max_r     <= '0;
            maxi_r    <= '0;
            idx       <= '0;
            for (int i = 0; i < N; i++) begin
                row_buf[i] <= '0;
            end
        end else begin
            o_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        for (int i = 0; i < N; i++) begin
                            row_buf[i] <= i_row[i];
                        end
                        max_r  <= i_row[0];
                        maxi_r <= '0;
                        idx    <= IW'(1);
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (cur > max_r) begin
                        max_r  <= cur;
                        maxi_r <= idx;
                    end
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= SUB;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                SUB: begin
                    row_buf[idx] <= sat_diff;
                    if (idx == LAST) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    for (int i = 0; i < N; i++) begin
                        o_row[i] <= row_buf[i];
                    end
                    o_max     <= max_r;
                    o_max_idx <= maxi_r;
                    o_valid   <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_row_max_sub.sv
// tb_softmax_row_max_sub: directed bench for softmax_row_max_sub.
// Scoreboard of expected rows; every output checked each cycle.
module tb_softmax_row_max_sub;

    localparam int N = 32;
    localparam int DW = 16;
    localparam int IW = 5;
    localparam int LAT = 2 * N;

    typedef logic [N-1:0][DW-1:0] row_t;

    typedef struct {
        row_t          row;
        logic [DW-1:0] mx;
        logic [IW-1:0] mi;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    row_t          in_row = '0;
    logic          ready;
    row_t          out_row;
    logic [DW-1:0] out_max;
    logic [IW-1:0] out_idx;
    logic          out_valid;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    int   cnt = 0;
    logic vld_m = 1'b0;
    exp_t hold = '{row: '0, mx: '0, mi: '0};
    logic ready_m;

    softmax_row_max_sub #(.N(N), .DW(DW)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (in_valid),
        .i_row     (in_row),
        .o_ready   (ready),
        .o_row     (out_row),
        .o_max     (out_max),
        .o_max_idx (out_idx),
        .o_valid   (out_valid)
    );

    always #5 clk = ~clk;

    function automatic exp_t ref_model(row_t r);
        exp_t e;
        int m;
        int mi;
        int d;
        m  = int'($signed(r[0]));
        mi = 0;
        for (int i = 1; i < N; i++) begin
            if (int'($signed(r[i])) > m) begin
                m  = int'($signed(r[i]));
                mi = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            d = int'($signed(r[i])) - m;
            if (d < -32768) d = -32768;
            e.row[i] = 16'(d);
        end
        e.mx = 16'(m);
        e.mi = 5'(mi);
        return e;
    endfunction

    assign ready_m = (cnt == 0);

    // Reference timing model: busy for 2N cycles after acceptance,
    // result pulse in the cycle after the last busy one.
    always @(posedge clk) begin
        if (rst) begin
            cnt   <= 0;
            vld_m <= 1'b0;
            hold  <= '{row: '0, mx: '0, mi: '0};
            sb.delete();
        end else begin
            vld_m <= 1'b0;
            if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    vld_m <= 1'b1;
                    checks++;
                    assert (sb.size() > 0) else begin
                        errors++;
                        $error("FAIL scoreboard: empty at result");
                    end
                    if (sb.size() > 0) hold <= sb.pop_front();
                end
            end else if (in_valid) begin
                sb.push_back(ref_model(in_row));
                cnt <= LAT;
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        assert (ready === ready_m) else begin
            errors++;
            $error("FAIL o_ready: got %b exp %b", ready, ready_m);
        end
        checks++;
        assert (out_valid === vld_m) else begin
            errors++;
            $error("FAIL o_valid: got %b exp %b", out_valid, vld_m);
        end
        checks++;
        assert (out_max === hold.mx) else begin
            errors++;
            $error("FAIL o_max: got %0d exp %0d",
                   $signed(out_max), $signed(hold.mx));
        end
        checks++;
        assert (out_idx === hold.mi) else begin
            errors++;
            $error("FAIL o_max_idx: got %0d exp %0d", out_idx, hold.mi);
        end
        checks++;
        assert (out_row === hold.row) else begin
            errors++;
            $error("FAIL o_row: got %h exp %h", out_row, hold.row);
        end
    end

    task automatic send_row(input row_t r);
        logic acc;
        in_row   = r;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int k = 0; k < 300 && !acc; k++) begin
            acc = ready_m;
            @(posedge clk);
            #1;
        end
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL accept: got timeout exp accept");
        end
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) in_row[i] = 16'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((cnt != 0 || vld_m) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        assert (k < 300) else begin
            errors++;
            $error("FAIL idle: got timeout exp idle");
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t r;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < N; i++) r[i] = 16'(i);
        send_row(r);
        wait_idle();

        for (int i = 0; i < N; i++) r[i] = 16'(-1000);
        send_row(r);
        wait_idle();

        for (int i = 0; i < N; i++) r[i] = 16'h8000;
        r[0] = 16'h7fff;
        send_row(r);
        wait_idle();

        for (int i = 0; i < N; i++) r[i] = 16'(-5);
        r[7]  = 16'(-2);
        r[20] = 16'(-2);
        send_row(r);
        wait_idle();

        in_valid = 1'b1;
        for (int c = 0; c < 3 * (LAT + 1) + 5; c++) begin
            for (int i = 0; i < N; i++) in_row[i] = 16'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_idle();

        for (int i = 0; i < N; i++) r[i] = 16'(i * 3 - 40);
        send_row(r);
        repeat (40) @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < N; i++) r[i] = 16'(i);
        send_row(r);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
